sim_exit_monitor: RTL

- Synthesisable-style simulation-control monitor for the SoC testbench.
- Snoops the CPU AHB-Lite master bus and per-hart retire pulses.
- Decodes pass/fail/console writes to a parametrised exit address, runs a per-hart no-retire watchdog and a global cycle timeout.
- Reports a sticky exit status and buffers console characters in a FIFO; the bench top polls the status and calls $finish.

---
 rtl/sim_mon_pkg.sv | 29 ++
 rtl/sim_mon_char_fifo.sv | 48 ++++
 rtl/sim_exit_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sim_mon_pkg.sv
// Shared constants for the simulation exit monitor: exit causes, magic
// pass/fail words written by software, and the AHB transfer types of interest.
package sim_mon_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_PASS    = 3'd1,
    CAUSE_SW_FAIL = 3'd2,
    CAUSE_WDOG    = 3'd3,
    CAUSE_TIMEOUT = 3'd4
  } sim_cause_e;

  localparam logic [31:0] PASS_CODE_LO = 32'h0000_0FFF;
  localparam logic [31:0] PASS_CODE_HI = 32'hFFFF_0000;
  localparam logic [31:0] FAIL_CODE_LO = 32'h0000_0EEE;
  localparam logic [31:0] FAIL_CODE_HI = 32'hEEEE_0000;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic logic is_pass_code(input logic [31:0] word);
    return (word == PASS_CODE_LO) || (word == PASS_CODE_HI);
  endfunction

  function automatic logic is_fail_code(input logic [31:0] word);
    return (word == FAIL_CODE_LO) || (word == FAIL_CODE_HI);
  endfunction

endpackage

// File: rtl/sim_mon_char_fifo.sv
// Console character FIFO. DEPTH must be a power of two (>= 2); pointers carry
// one extra wrap bit so full and empty are distinguishable. A push while full
// is accepted only when a pop happens in the same cycle.
module sim_mon_char_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Pointer update, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sim_exit_monitor.sv
// Simulation exit monitor: snoops AHB writes to EXIT_ADDR for pass/fail/console
// words, runs a per-hart no-retire watchdog and a global cycle timeout, and
// reports a sticky exit status.
// Build option: define SIM_EXIT_CHAR_FIFO_EN to buffer console bytes in a FIFO;
// otherwise each console byte appears as a one-cycle char_valid pulse.
module sim_exit_monitor
  import sim_mon_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_HARTS   = 1,
  parameter logic [ADDR_W-1:0] EXIT_ADDR   = ADDR_W'(32'h6000_FFF8),
  parameter int unsigned       WDOG_CYCLES = 5000,
  parameter int unsigned       MAX_CYCLES  = 70_000_000,
  parameter int unsigned       CHAR_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [1:0]           htrans,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic                 hwrite,
  input  logic                 hready,
  input  logic [DATA_W-1:0]    hwdata,
  input  logic [NUM_HARTS-1:0] retire,
  output logic                 sim_done,
  output logic                 sim_pass,
  output logic [2:0]           sim_cause,
  output logic [2:0]           wdog_hart,
  output logic                 char_valid,
  output logic [7:0]           char_data,
  input  logic                 char_ready,
  output logic [15:0]          char_drops,
  output logic [31:0]          cycle_cnt
);

  // Idle counters stop one past the trip point, so size for WDOG_CYCLES.
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic                 pending_reg;
  logic                 addr_hit;
  logic                 data_fire;
  logic                 word_pass;
  logic                 word_fail;
  logic                 push_req;
  logic [7:0]           push_byte;
  logic                 sim_done_reg, sim_done_next;
  sim_cause_e           cause_reg, cause_next;
  logic [2:0]           wdog_hart_reg, wdog_hart_next;
  logic [31:0]          cycle_cnt_reg;
  logic [NUM_HARTS-1:0] wdog_trip;
  logic                 trip_any;
  logic [2:0]           trip_idx;
  logic                 unused_ok;

  assign addr_hit  = hwrite && (haddr == EXIT_ADDR) &&
                     ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign data_fire = hready && pending_reg;
  assign word_pass = is_pass_code(hwdata[31:0]);
  assign word_fail = is_fail_code(hwdata[31:0]);
  assign push_req  = data_fire && !word_pass && !word_fail;
  assign push_byte = hwdata[7:0];

  // Address phase: hold the hit across wait states until the data phase completes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      pending_reg <= 1'b0;
    else if (hready) pending_reg <= addr_hit;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      logic [WDOG_W-1:0] idle_reg;

      // Per-hart idle counter: cleared by a retire, frozen once the run is over.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)             idle_reg <= '0;
        else if (retire[gi])    idle_reg <= '0;
        else if (!sim_done_reg) idle_reg <= idle_reg + 1'b1;
      end

      assign wdog_trip[gi] = !retire[gi] && (idle_reg == WDOG_W'(WDOG_CYCLES - 1));
    end
  endgenerate

  // Pick the lowest hart index among those tripping this cycle.
  always_comb begin
    trip_any = 1'b0;
    trip_idx = 3'd0;
    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      if (wdog_trip[h] && !trip_any) begin
        trip_any = 1'b1;
        trip_idx = 3'(h);
      end
    end
  end

  // Exit decision with priority bus pass/fail > watchdog > timeout; sticky once set.
  always_comb begin
    sim_done_next  = sim_done_reg;
    cause_next     = cause_reg;
    wdog_hart_next = wdog_hart_reg;
    if (!sim_done_reg) begin
      if (data_fire && word_pass) begin
        sim_done_next = 1'b1;
        cause_next    = CAUSE_PASS;
      end else if (data_fire && word_fail) begin
        sim_done_next = 1'b1;
        cause_next    = CAUSE_SW_FAIL;
      end else if (trip_any) begin
        sim_done_next  = 1'b1;
        cause_next     = CAUSE_WDOG;
        wdog_hart_next = trip_idx;
      end else if (cycle_cnt_reg == 32'(MAX_CYCLES - 1)) begin
        sim_done_next = 1'b1;
        cause_next    = CAUSE_TIMEOUT;
      end
    end
  end

  // Status and global cycle counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sim_done_reg  <= 1'b0;
      cause_reg     <= CAUSE_NONE;
      wdog_hart_reg <= 3'd0;
      cycle_cnt_reg <= '0;
    end else begin
      sim_done_reg  <= sim_done_next;
      cause_reg     <= cause_next;
      wdog_hart_reg <= wdog_hart_next;
      if (!sim_done_reg && (cycle_cnt_reg != '1)) cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
    end
  end

  assign sim_done  = sim_done_reg;
  assign sim_cause = cause_reg;
  assign sim_pass  = (cause_reg == CAUSE_PASS);
  assign wdog_hart = wdog_hart_reg;
  assign cycle_cnt = cycle_cnt_reg;

`ifdef SIM_EXIT_CHAR_FIFO_EN
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [7:0]  fifo_head;
  logic [7:0]  char_hold_reg;
  logic [15:0] drops_reg;

  assign fifo_pop = char_ready && !fifo_empty;

  sim_mon_char_fifo #(
    .DEPTH (CHAR_DEPTH)
  ) u_char_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push_req),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign char_valid = !fifo_empty;
  assign char_data  = fifo_empty ? char_hold_reg : fifo_head;
  assign char_drops = drops_reg;
  assign unused_ok  = ^hwdata;

  // Remember the last visible byte so char_data is stable while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) char_hold_reg <= 8'h00;
    else        char_hold_reg <= char_data;
  end

  // Saturating count of bytes lost to a full FIFO with no pop in the same cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) drops_reg <= 16'h0000;
    else if (push_req && fifo_full && !fifo_pop && (drops_reg != 16'hFFFF))
      drops_reg <= drops_reg + 16'h0001;
  end
`else
  logic       char_valid_reg;
  logic [7:0] char_data_reg;

  assign char_valid = char_valid_reg;
  assign char_data  = char_data_reg;
  assign char_drops = 16'h0000;
  assign unused_ok  = ^{char_ready, hwdata};

  // Unbuffered console: one-cycle pulse carrying the byte, data held afterwards.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      char_valid_reg <= 1'b0;
      char_data_reg  <= 8'h00;
    end else begin
      char_valid_reg <= push_req;
      if (push_req) char_data_reg <= push_byte;
    end
  end
`endif

endmodule
